pipe_stage_reg: RTL

- Generic parametrised pipeline stage register, the successor to the fixed-field ID/EX latch.
- Carries an opaque data payload and a control word between stages with a valid/ready handshake, a 2-entry skid buffer, flush, and bubble insertion.
- Intended for every inter-stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB) so that stall and flush are handled uniformly.

---
 rtl/pipe_stage_reg.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register: valid/ready handshake with a 2-entry skid buffer, plus flush and bubble masking.
// Latency: 1 cycle from accept to out_*; full throughput of 1 entry/cycle while downstream is ready.
// Backpressure: in_ready_o comes from a flop; it drops only when both entries are held. Macro PIPE_STAGE_PERF_EN enables the counters.
module pipe_stage_reg #(
  parameter int unsigned          DATA_W      = 128,
  parameter int unsigned          CTRL_W      = 32,
  parameter logic [CTRL_W-1:0]    BUBBLE_CTRL = '0,
  parameter int unsigned          CNT_W       = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [1:0]        occupancy_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
);

  // State encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                in_ready_q, in_ready_d;
  logic [DATA_W-1:0]   m_data_q, m_data_d;
  logic [CTRL_W-1:0]   m_ctrl_q, m_ctrl_d;
  logic [DATA_W-1:0]   s_data_q, s_data_d;
  logic [CTRL_W-1:0]   s_ctrl_q, s_ctrl_d;
  logic                accept;
  logic                consume;

  assign accept  = in_valid_i & in_ready_q;
  assign consume = (state_q != EMPTY) & out_ready_i;

  // Next-state and data-path steering; flush overrides everything, data regs keep their contents.
  always_comb begin
    state_d  = state_q;
    m_data_d = m_data_q;
    m_ctrl_d = m_ctrl_q;
    s_data_d = s_data_q;
    s_ctrl_d = s_ctrl_q;
    if (flush_i) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            m_data_d = in_data_i;
            m_ctrl_d = in_ctrl_i;
            state_d  = ONE;
          end
        end
        ONE: begin
          if (accept && consume) begin
            m_data_d = in_data_i;
            m_ctrl_d = in_ctrl_i;
          end else if (accept) begin
            s_data_d = in_data_i;
            s_ctrl_d = in_ctrl_i;
            state_d  = FULL;
          end else if (consume) begin
            state_d  = EMPTY;
          end
        end
        FULL: begin
          if (consume) begin
            m_data_d = s_data_q;
            m_ctrl_d = s_ctrl_q;
            state_d  = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
    in_ready_d = (state_d != FULL);
  end

  // State, ready and entry registers; reset clears everything and reopens the input.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
      m_data_q   <= '0;
      m_ctrl_q   <= '0;
      s_data_q   <= '0;
      s_ctrl_q   <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      m_data_q   <= m_data_d;
      m_ctrl_q   <= m_ctrl_d;
      s_data_q   <= s_data_d;
      s_ctrl_q   <= s_ctrl_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = (state_q != EMPTY);
  assign out_data_o  = m_data_q;
  assign out_ctrl_o  = out_valid_o ? m_ctrl_q : BUBBLE_CTRL;
  assign occupancy_o = state_q;

`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Saturating stall and bubble counters; only reset clears them.
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (out_valid_o && !out_ready_i && !flush_i && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    if (!out_valid_o && (bubble_cnt_q != '1))
      bubble_cnt_d = bubble_cnt_q + CNT_ONE;
  end

  // Counter registers.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign stall_cnt_o  = stall_cnt_q;
  assign bubble_cnt_o = bubble_cnt_q;
`else
  assign stall_cnt_o  = '0;
  assign bubble_cnt_o = '0;
`endif

endmodule
